// File: rtl/divide16by8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_TRAP_EN to short-cut a zero divisor to a one-cycle result with div_zero set.
`timescale 1ns/1ps

module divide16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_TRAP
  } state_t;

  state_t      r_state;
  logic [15:0] r_q;
  logic [7:0]  r_d;
  logic [7:0]  r_r;
  logic [4:0]  r_cnt;

  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_remNext;
  logic [15:0] w_quoNext;

  // The partial remainder always stays below D, so 8 stored bits suffice;
  // the 9th bit only exists in the shifted trial value.
  assign w_shift   = {r_r, r_q[15]};
  assign w_ge      = (w_shift >= {1'b0, r_d});
  assign w_remNext = w_ge ? (w_shift[7:0] - r_d) : w_shift[7:0];
  assign w_quoNext = {r_q[14:0], w_ge};

`ifdef DIV_ZERO_TRAP_EN
  logic r_divZero;
  assign div_zero = r_divZero;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_d       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
      r_divZero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= '0;
            busy  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            r_state <= (divisor == 8'd0) ? S_TRAP : S_RUN;
`else
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_q   <= w_quoNext;
          r_r   <= w_remNext;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            quotient  <= w_quoNext;
            remainder <= w_remNext;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
`ifdef DIV_ZERO_TRAP_EN
            r_divZero <= 1'b0;
`endif
          end
        end
`ifdef DIV_ZERO_TRAP_EN
        // Same result the plain algorithm would reach, delivered without iterating
        S_TRAP: begin
          quotient  <= 16'hFFFF;
          remainder <= r_q[7:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          r_divZero <= 1'b1;
          r_state   <= S_IDLE;
        end
`endif
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide16by8.sv
// Self-checking bench for divide16by8 using an expected-result queue.
// Honours DIV_ZERO_TRAP_EN the same way the design does.
`timescale 1ns/1ps

module tb_divide16by8;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  exp_t sb[$];
  int   testsRun;
  int   testsFailed;

  divide16by8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what a correct divider must report for these operands
  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    if (dvs == 8'd0) begin
      e.q = 16'hFFFF;
      e.r = dvd[7:0];
    end else begin
      e.q = dvd / {8'd0, dvs};
      e.r = 8'(dvd % {8'd0, dvs});
    end
`ifdef DIV_ZERO_TRAP_EN
    e.dz  = (dvs == 8'd0);
    e.lat = (dvs == 8'd0) ? 1 : 16;
`else
    e.dz  = 1'b0;
    e.lat = 16;
`endif
    return e;
  endfunction

  // Called #1 after an edge; drives one accept edge and queues the expected result
  task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs, input bit holdStart);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    sb.push_back(model(dvd, dvs));
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
    dividend = $urandom;
    divisor  = 8'($urandom);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!done && cycles < 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #12;
    testsRun++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
               busy, done, quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [15:0] dvds[5] = '{16'h03E8, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h00C8};
    logic [7:0]  dvss[5] = '{8'h07, 8'hFF, 8'h01, 8'h09, 8'h0A};
    exp_t e;
    int cyc;
    for (int i = 0; i < 5; i++) begin
      issue(dvds[i], dvss[i], 1'b0);
      testsRun++;
      if (busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL basic_busy[%0d]: got %b, want 1", i, busy);
      end
      waitDone(cyc);
      e = sb.pop_front();
      testsRun++;
      if (done !== 1'b1 || cyc != e.lat) begin
        testsFailed++;
        $display("[TB] FAIL basic_latency[%0d]: got done=%b after %0d cycles, want %0d", i, done, cyc, e.lat);
      end
      testsRun++;
      if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz || busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL basic_result[%0d]: got q=%h r=%h dz=%b busy=%b, want q=%h r=%h dz=%b busy=0",
                 i, quotient, remainder, div_zero, busy, e.q, e.r, e.dz);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (done !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
        testsFailed++;
        $display("[TB] FAIL basic_pulse[%0d]: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
                 i, done, quotient, remainder, e.q, e.r);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int cyc;
    int seen;
    logic [15:0] qMid;
    issue(16'h03E8, 8'h07, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    qMid     = quotient;
    start    = 1'b1;
    dividend = 16'hAAAA;
    divisor  = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    testsRun++;
    if (quotient !== qMid) begin
      testsFailed++;
      $display("[TB] FAIL ignore_hold: quotient moved during run, got %h want %h", quotient, qMid);
    end
    waitDone(cyc);
    e = sb.pop_front();
    testsRun++;
    if (done !== 1'b1 || cyc + 5 != 16) begin
      testsFailed++;
      $display("[TB] FAIL ignore_latency: got done=%b after %0d cycles, want 16", done, cyc + 5);
    end
    testsRun++;
    if (quotient !== e.q || remainder !== e.r) begin
      testsFailed++;
      $display("[TB] FAIL ignore_result: got q=%h r=%h, want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    testsRun++;
    if (seen != 0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_queued: got %0d busy/done cycles afterwards, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    issue(16'h7531, 8'h0D, 1'b1);
    waitDone(cyc);
    e = sb.pop_front();
    testsRun++;
    if (done !== 1'b1 || cyc != e.lat || quotient !== e.q || remainder !== e.r) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got done=%b cyc=%0d q=%h r=%h, want cyc=%0d q=%h r=%h",
               done, cyc, quotient, remainder, e.lat, e.q, e.r);
    end
    issue(16'hBEEF, 8'h2B, 1'b0);
    testsRun++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept: got busy=%b done=%b at T+17, want busy=1 done=0", busy, done);
    end
    waitDone(cyc);
    e = sb.pop_front();
    testsRun++;
    if (done !== 1'b1 || cyc != e.lat || quotient !== e.q || remainder !== e.r) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got done=%b cyc=%0d q=%h r=%h, want cyc=%0d q=%h r=%h",
               done, cyc, quotient, remainder, e.lat, e.q, e.r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero;
    exp_t e;
    int cyc;
    issue(16'h1234, 8'h00, 1'b0);
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL divzero_busy: got %b, want 1", busy);
    end
    waitDone(cyc);
    e = sb.pop_front();
    testsRun++;
    if (done !== 1'b1 || cyc != e.lat) begin
      testsFailed++;
      $display("[TB] FAIL divzero_latency: got done=%b after %0d cycles, want %0d", done, cyc, e.lat);
    end
    testsRun++;
    if (quotient !== 16'hFFFF || remainder !== 8'h34 || div_zero !== e.dz || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL divzero_result: got q=%h r=%h dz=%b busy=%b, want q=ffff r=34 dz=%b busy=0",
               quotient, remainder, div_zero, busy, e.dz);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int cyc;
    int seen;
    issue(16'h03E8, 8'h07, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    testsRun++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_clear: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
               busy, done, quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    testsRun++;
    if (seen != 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_nodone: got %0d done pulses, want 0", seen);
    end
    issue(16'h00C8, 8'h0A, 1'b0);
    waitDone(cyc);
    e = sb.pop_front();
    testsRun++;
    if (done !== 1'b1 || cyc != 16 || quotient !== 16'h0014 || remainder !== 8'h00 || e.q !== 16'h0014) begin
      testsFailed++;
      $display("[TB] FAIL midreset_next: got done=%b cyc=%0d q=%h r=%h, want cyc=16 q=0014 r=00",
               done, cyc, quotient, remainder);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    exp_t e;
    int cyc;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    for (int i = 0; i < 2000; i++) begin
      dvd = 16'($urandom);
      dvs = 8'($urandom_range(1, 255));
      issue(dvd, dvs, 1'b0);
      waitDone(cyc);
      e = sb.pop_front();
      testsRun++;
      if (done !== 1'b1 || cyc != 16 || quotient !== e.q || remainder !== e.r ||
          ({8'd0, quotient} * {16'd0, dvs} + {16'd0, remainder}) != {8'd0, dvd} || remainder >= dvs) begin
        testsFailed++;
        $display("[TB] FAIL random[%0d]: %h/%h got done=%b cyc=%0d q=%h r=%h, want q=%h r=%h",
                 i, dvd, dvs, done, cyc, quotient, remainder, e.q, e.r);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
